// File: rtl/election_pkg.sv
// Shared types for the parametric election controller: election phases,
// request mode encodings and the bundle of one-cycle error pulses.
package election_pkg;

    typedef enum logic [1:0] {
        PH_REG   = 2'd0,
        PH_VOTE  = 2'd1,
        PH_TALLY = 2'd2,
        PH_DONE  = 2'd3
    } phase_e;

    localparam logic [1:0] MODE_REGISTER = 2'd0;
    localparam logic [1:0] MODE_VOTE     = 2'd1;

    typedef struct packed {
        logic alreadyRegistered;
        logic notRegistered;
        logic alreadyVoted;
        logic votingHasNotStarted;
        logic registrationHasEnded;
        logic invalidRequest;
    } err_t;

endpackage

// File: rtl/parametric_election_ctrl_if.sv
// Request/status bundle of the election controller; the master side issues
// register/vote requests, the slave side is the controller itself.
interface parametric_election_ctrl_if
    import election_pkg::*;
#(
    parameter int ID_W     = 6,
    parameter int NUM_CAND = 4,
    parameter int BOX_W    = 2
);
    localparam int CAND_W = $clog2(NUM_CAND);

    logic              in_valid;
    logic [1:0]        mode;
    logic [ID_W-1:0]   userID;
    logic [CAND_W-1:0] candidate;

    logic [BOX_W-1:0]  ballotBoxId;
    phase_e            phase;
    logic [ID_W:0]     numberOfRegisteredVoters;
    logic              AlreadyRegistered;
    logic              NotRegistered;
    logic              AlreadyVoted;
    logic              VotingHasNotStarted;
    logic              RegistrationHasEnded;
    logic              InvalidRequest;
    logic              result_valid;
    logic [CAND_W-1:0] WinnerId;
    logic [ID_W:0]     numberOfVotesWinner;
    logic              tie;

    modport master (
        output in_valid, mode, userID, candidate,
        input  ballotBoxId, phase, numberOfRegisteredVoters,
               AlreadyRegistered, NotRegistered, AlreadyVoted,
               VotingHasNotStarted, RegistrationHasEnded, InvalidRequest,
               result_valid, WinnerId, numberOfVotesWinner, tie
    );

    modport slave (
        input  in_valid, mode, userID, candidate,
        output ballotBoxId, phase, numberOfRegisteredVoters,
               AlreadyRegistered, NotRegistered, AlreadyVoted,
               VotingHasNotStarted, RegistrationHasEnded, InvalidRequest,
               result_valid, WinnerId, numberOfVotesWinner, tie
    );

endinterface

// File: rtl/election_tally.sv
// Per-candidate vote counters plus a one-candidate-per-cycle max scan.
// While start is high the scan walks indices 0..NUM_CAND-1; done marks the last one.
module election_tally #(
    parameter int ID_W     = 6,
    parameter int NUM_CAND = 4,
    localparam int CAND_W  = $clog2(NUM_CAND)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              voteEn,
    input  logic [CAND_W-1:0] voteCand,
    input  logic              start,
    output logic              done,
    output logic [CAND_W-1:0] winner,
    output logic [ID_W:0]     bestVotes,
    output logic              tie
);

    localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

    logic [ID_W:0]     votes [NUM_CAND];
    logic [CAND_W-1:0] idx;
    logic [ID_W:0]     curVotes;

    always_comb begin
        curVotes = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (idx == CAND_W'(i)) curVotes = votes[i];
        end
    end

    assign done = start && (idx == LAST_IDX);

    // Strict greater-than keeps the lowest index on equal counts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CAND; i++) votes[i] <= '0;
            idx       <= '0;
            winner    <= '0;
            bestVotes <= '0;
            tie       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (voteEn && (voteCand == CAND_W'(i))) votes[i] <= votes[i] + 1'b1;
            end
            if (start) begin
                if (idx == '0) begin
                    bestVotes <= curVotes;
                    winner    <= '0;
                    tie       <= 1'b0;
                end else if (curVotes > bestVotes) begin
                    bestVotes <= curVotes;
                    winner    <= idx;
                    tie       <= 1'b0;
                end else if (curVotes == bestVotes) begin
                    tie <= 1'b1;
                end
                if (!done) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/parametric_election_ctrl.sv
// Timed election controller: registration window, voting window, sequential
// tally, then results held until reset. All outputs come from registers.
module parametric_election_ctrl
    import election_pkg::*;
#(
    parameter int ID_W        = 6,
    parameter int NUM_CAND    = 4,
    parameter int BOX_W       = 2,
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100
) (
    input logic CLK,
    input logic RST,
    parametric_election_ctrl_if.slave bus
);

    localparam int CAND_W  = $clog2(NUM_CAND);
    localparam int DEPTH   = 2 ** ID_W;
    localparam int CNT_MAX = REG_CYCLES + VOTE_CYCLES + NUM_CAND;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // cycleCnt holds the number of cycles already completed since reset.
    localparam logic [CNT_W-1:0] REG_LAST  = CNT_W'(REG_CYCLES - 1);
    localparam logic [CNT_W-1:0] VOTE_LAST = CNT_W'(REG_CYCLES + VOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

    phase_e            phase, phaseNext;
    logic [CNT_W-1:0]  cycleCnt;
    logic [DEPTH-1:0]  regMap, votedMap;
    logic [ID_W:0]     regCount;
    err_t              errNext, errQ;
    logic              doRegister, doVote;
    logic              candInvalid;
    logic              tallyStart, tallyDone;
    logic              resultValid;
    logic [BOX_W-1:0]  boxQ;
    logic [CAND_W-1:0] winnerId;
    logic [ID_W:0]     winnerVotes;
    logic              tieQ;

    assign candInvalid = {1'b0, bus.candidate} >= (CAND_W + 1)'(NUM_CAND);
    assign tallyStart  = (phase == PH_TALLY);

    always_comb begin
        phaseNext  = phase;
        errNext    = '0;
        doRegister = 1'b0;
        doVote     = 1'b0;
        case (phase)
            PH_REG: begin
                if (cycleCnt == REG_LAST) phaseNext = PH_VOTE;
                if (bus.in_valid) begin
                    if (bus.mode == MODE_REGISTER) begin
                        if (regMap[bus.userID]) errNext.alreadyRegistered = 1'b1;
                        else                    doRegister = 1'b1;
                    end else if (bus.mode == MODE_VOTE) begin
                        errNext.votingHasNotStarted = 1'b1;
                    end else begin
                        errNext.invalidRequest = 1'b1;
                    end
                end
            end
            PH_VOTE: begin
                if (cycleCnt == VOTE_LAST) phaseNext = PH_TALLY;
                if (bus.in_valid) begin
                    if (bus.mode == MODE_REGISTER) begin
                        errNext.registrationHasEnded = 1'b1;
                    end else if (bus.mode == MODE_VOTE) begin
                        if (candInvalid)                  errNext.invalidRequest = 1'b1;
                        else if (!regMap[bus.userID])     errNext.notRegistered  = 1'b1;
                        else if (votedMap[bus.userID])    errNext.alreadyVoted   = 1'b1;
                        else                              doVote = 1'b1;
                    end else begin
                        errNext.invalidRequest = 1'b1;
                    end
                end
            end
            default: begin
                if ((phase == PH_TALLY) && tallyDone) phaseNext = PH_DONE;
                if (bus.in_valid) begin
                    if (bus.mode == MODE_VOTE) errNext.registrationHasEnded = 1'b1;
                    else                       errNext.invalidRequest       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase       <= PH_REG;
            cycleCnt    <= '0;
            regMap      <= '0;
            votedMap    <= '0;
            regCount    <= '0;
            errQ        <= '0;
            boxQ        <= '0;
            resultValid <= 1'b0;
        end else begin
            phase <= phaseNext;
            errQ  <= errNext;
            if (cycleCnt != CNT_SAT) cycleCnt <= cycleCnt + 1'b1;
            if (bus.in_valid) boxQ <= bus.userID[ID_W-1 -: BOX_W];
            if (doRegister) begin
                regMap[bus.userID] <= 1'b1;
                regCount           <= regCount + 1'b1;
            end
            if (doVote) votedMap[bus.userID] <= 1'b1;
            if (tallyStart && tallyDone) resultValid <= 1'b1;
        end
    end

    election_tally #(
        .ID_W     (ID_W),
        .NUM_CAND (NUM_CAND)
    ) tally (
        .CLK       (CLK),
        .RST       (RST),
        .voteEn    (doVote),
        .voteCand  (bus.candidate),
        .start     (tallyStart),
        .done      (tallyDone),
        .winner    (winnerId),
        .bestVotes (winnerVotes),
        .tie       (tieQ)
    );

    assign bus.phase                    = phase;
    assign bus.ballotBoxId              = boxQ;
    assign bus.numberOfRegisteredVoters = regCount;
    assign bus.AlreadyRegistered        = errQ.alreadyRegistered;
    assign bus.NotRegistered            = errQ.notRegistered;
    assign bus.AlreadyVoted             = errQ.alreadyVoted;
    assign bus.VotingHasNotStarted      = errQ.votingHasNotStarted;
    assign bus.RegistrationHasEnded     = errQ.registrationHasEnded;
    assign bus.InvalidRequest           = errQ.invalidRequest;
    assign bus.result_valid             = resultValid;
    assign bus.WinnerId                 = winnerId;
    assign bus.numberOfVotesWinner      = winnerVotes;
    assign bus.tie                      = tieQ;

endmodule

// File: tb/tb_parametric_election_ctrl.sv
// Bench for parametric_election_ctrl: directed election scenarios checked every
// cycle against a cycle-numbered model of the election rules, plus literal spot checks.
module tb_parametric_election_ctrl;

    localparam int ID_W        = 4;
    localparam int NUM_CAND    = 3;
    localparam int BOX_W       = 2;
    localparam int REG_CYCLES  = 8;
    localparam int VOTE_CYCLES = 8;
    localparam int NUM_IDS     = 2 ** ID_W;
    localparam int DONE_CYCLE  = REG_CYCLES + VOTE_CYCLES + NUM_CAND;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    parametric_election_ctrl_if #(.ID_W(ID_W), .NUM_CAND(NUM_CAND), .BOX_W(BOX_W)) bus ();

    parametric_election_ctrl #(
        .ID_W        (ID_W),
        .NUM_CAND    (NUM_CAND),
        .BOX_W       (BOX_W),
        .REG_CYCLES  (REG_CYCLES),
        .VOTE_CYCLES (VOTE_CYCLES)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Model state: cyc is the number of the cycle whose edge was just taken.
    bit mRegistered [NUM_IDS];
    bit mVoted      [NUM_IDS];
    int mVotes      [NUM_CAND];
    int mCount;
    int mBox;
    int mFlags;
    int cyc;
    bit modelValid = 1'b0;

    localparam int F_AR = 32, F_NR = 16, F_AV = 8, F_VHNS = 4, F_RHE = 2, F_IR = 1;

    function automatic int phaseOf(input int n);
        if (n <= REG_CYCLES)               return 0;
        if (n <= REG_CYCLES + VOTE_CYCLES) return 1;
        if (n <= DONE_CYCLE)               return 2;
        return 3;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t, cycle %0d)",
                     name, actual, expected, $time, cyc);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                mRegistered[i] = 1'b0;
                mVoted[i]      = 1'b0;
            end
            for (int i = 0; i < NUM_CAND; i++) mVotes[i] = 0;
            mCount     = 0;
            mBox       = 0;
            mFlags     = 0;
            cyc        = 0;
            modelValid = 1'b1;
        end else begin
            cyc++;
            mFlags = 0;
            if (bus.in_valid) begin
                int id, md, cd;
                id   = int'(bus.userID);
                md   = int'(bus.mode);
                cd   = int'(bus.candidate);
                mBox = id / (2 ** (ID_W - BOX_W));
                case (phaseOf(cyc))
                    0: begin
                        if (md == 0) begin
                            if (mRegistered[id]) mFlags = F_AR;
                            else begin
                                mRegistered[id] = 1'b1;
                                mCount++;
                            end
                        end else if (md == 1) mFlags = F_VHNS;
                        else                  mFlags = F_IR;
                    end
                    1: begin
                        if (md == 0) mFlags = F_RHE;
                        else if (md == 1) begin
                            if (cd >= NUM_CAND)       mFlags = F_IR;
                            else if (!mRegistered[id]) mFlags = F_NR;
                            else if (mVoted[id])       mFlags = F_AV;
                            else begin
                                mVoted[id] = 1'b1;
                                mVotes[cd]++;
                            end
                        end else mFlags = F_IR;
                    end
                    default: mFlags = (md == 1) ? F_RHE : F_IR;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (modelValid) begin
            int best, win, nBest;
            best = -1;
            win  = 0;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (mVotes[i] > best) begin
                    best = mVotes[i];
                    win  = i;
                end
            end
            nBest = 0;
            for (int i = 0; i < NUM_CAND; i++) if (mVotes[i] == best) nBest++;
            checkOutput("phase", int'(bus.phase), phaseOf(cyc + 1));
            checkOutput("regCount", int'(bus.numberOfRegisteredVoters), mCount);
            checkOutput("ballotBoxId", int'(bus.ballotBoxId), mBox);
            checkOutput("errorFlags", int'({bus.AlreadyRegistered, bus.NotRegistered,
                        bus.AlreadyVoted, bus.VotingHasNotStarted,
                        bus.RegistrationHasEnded, bus.InvalidRequest}), mFlags);
            checkOutput("resultValid", int'(bus.result_valid), (cyc >= DONE_CYCLE) ? 1 : 0);
            if (cyc <= REG_CYCLES + VOTE_CYCLES) begin
                checkOutput("winnerIdle", int'(bus.WinnerId), 0);
                checkOutput("winnerVotesIdle", int'(bus.numberOfVotesWinner), 0);
                checkOutput("tieIdle", int'(bus.tie), 0);
            end else if (cyc >= DONE_CYCLE) begin
                checkOutput("winnerId", int'(bus.WinnerId), win);
                checkOutput("winnerVotes", int'(bus.numberOfVotesWinner), best);
                checkOutput("tie", int'(bus.tie), (nBest > 1) ? 1 : 0);
            end
        end
    end

    task automatic applyStimulus(input bit v, input int md, input int id, input int cd);
        bus.in_valid  = v;
        bus.mode      = 2'(md);
        bus.userID    = ID_W'(id);
        bus.candidate = 2'(cd);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0);
    endtask

    task automatic doReset();
        RST           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = '0;
        bus.userID    = '0;
        bus.candidate = '0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        // Main scenario: registrations, errors, votes, winner candidate 2.
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("c2VotingHasNotStarted", int'(bus.VotingHasNotStarted), 1);
        applyStimulus(1, 0, 2, 0);
        applyStimulus(1, 0, 3, 0);
        applyStimulus(1, 0, 2, 0);
        checkOutput("c5RegCount", int'(bus.numberOfRegisteredVoters), 3);
        checkOutput("c5AlreadyRegistered", int'(bus.AlreadyRegistered), 1);
        applyStimulus(1, 2, 7, 0);
        checkOutput("c6AlreadyRegisteredCleared", int'(bus.AlreadyRegistered), 0);
        checkOutput("c6InvalidMode", int'(bus.InvalidRequest), 1);
        applyStimulus(0, 0, 9, 0);
        checkOutput("c7IgnoredRegCount", int'(bus.numberOfRegisteredVoters), 3);
        checkOutput("c7BoxHeld", int'(bus.ballotBoxId), 1);
        applyStimulus(1, 0, 12, 0);
        checkOutput("c8LastRegCount", int'(bus.numberOfRegisteredVoters), 4);
        checkOutput("c8PhaseVote", int'(bus.phase), 1);
        applyStimulus(1, 0, 6, 0);
        checkOutput("c9RegistrationHasEnded", int'(bus.RegistrationHasEnded), 1);
        applyStimulus(1, 1, 1, 2);
        applyStimulus(1, 1, 2, 2);
        applyStimulus(1, 1, 3, 0);
        applyStimulus(1, 1, 1, 1);
        checkOutput("c13AlreadyVoted", int'(bus.AlreadyVoted), 1);
        applyStimulus(1, 1, 5, 0);
        checkOutput("c14NotRegistered", int'(bus.NotRegistered), 1);
        applyStimulus(1, 1, 2, 3);
        checkOutput("c15BadCandidate", int'(bus.InvalidRequest), 1);
        applyStimulus(1, 1, 12, 1);
        checkOutput("c16PhaseTally", int'(bus.phase), 2);
        applyStimulus(1, 1, 4, 0);
        checkOutput("c17TallyVote", int'(bus.RegistrationHasEnded), 1);
        applyStimulus(1, 0, 4, 0);
        checkOutput("c18TallyRegister", int'(bus.InvalidRequest), 1);
        checkOutput("c18NotYetValid", int'(bus.result_valid), 0);
        idle(1);
        checkOutput("c19ResultValid", int'(bus.result_valid), 1);
        checkOutput("c19WinnerId", int'(bus.WinnerId), 2);
        checkOutput("c19WinnerVotes", int'(bus.numberOfVotesWinner), 2);
        checkOutput("c19Tie", int'(bus.tie), 0);
        checkOutput("c19PhaseDone", int'(bus.phase), 3);
        idle(3);

        // Tie between candidates 1 and 0: lowest index wins.
        doReset();
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 2, 0);
        idle(6);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(1, 1, 2, 0);
        idle(9);
        checkOutput("tieWinnerId", int'(bus.WinnerId), 0);
        checkOutput("tieWinnerVotes", int'(bus.numberOfVotesWinner), 1);
        checkOutput("tieFlag", int'(bus.tie), 1);

        // No votes at all, then a long hold of the result.
        doReset();
        idle(DONE_CYCLE);
        checkOutput("emptyTie", int'(bus.tie), 1);
        idle(50);
        checkOutput("emptyHeldValid", int'(bus.result_valid), 1);
        checkOutput("emptyHeldWinner", int'(bus.WinnerId), 0);
        checkOutput("emptyHeldVotes", int'(bus.numberOfVotesWinner), 0);

        // Reset in the middle of the tally scan.
        doReset();
        applyStimulus(1, 0, 1, 0);
        idle(7);
        applyStimulus(1, 1, 1, 1);
        idle(9);
        checkOutput("preResetPhaseTally", int'(bus.phase), 2);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("abortPhase", int'(bus.phase), 0);
        checkOutput("abortRegCount", int'(bus.numberOfRegisteredVoters), 0);
        checkOutput("abortWinnerVotes", int'(bus.numberOfVotesWinner), 0);
        checkOutput("abortWinnerId", int'(bus.WinnerId), 0);
        RST = 1'b0;
        applyStimulus(1, 0, 1, 0);
        checkOutput("reRegisterCount", int'(bus.numberOfRegisteredVoters), 1);
        checkOutput("reRegisterNoFlag", int'(bus.AlreadyRegistered), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
